// File: rtl/sub_bytes_seq.sv
// Sequential AES-128 forward SubBytes: substitutes BYTES_PER_CYCLE bytes of the
// 128-bit state per busy cycle, with valid/ready handshakes on both sides.
module sub_bytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CB     = 8 * BYTES_PER_CYCLE;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    sbuf;
  logic [CB-1:0]   chunk_in;
  logic [CB-1:0]   chunk_out;
  logic [127:0]    sbuf_nxt;

  // Mux the active chunk into a single bank of BYTES_PER_CYCLE S-boxes, then
  // merge the substituted chunk back in place (chunk 0 at the MSB end).
  always_comb begin
    chunk_in  = '0;
    chunk_out = '0;
    sbuf_nxt  = sbuf;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (cnt == CW'(c)) chunk_in = sbuf[127 - c*CB -: CB];
    end
    for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
      chunk_out[k*8 +: 8] = SBOX[chunk_in[k*8 +: 8]];
    end
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (cnt == CW'(c)) sbuf_nxt[127 - c*CB -: CB] = chunk_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sbuf      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sbuf     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sbuf <= sbuf_nxt;
          if (cnt == CW'(NCHUNK - 1)) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_data = sbuf;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: one instance per legal BYTES_PER_CYCLE, checked
// against an S-box derived from GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_seq;

  logic         clk;
  logic         rst;
  logic [4:0]   in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [127:0] in_data_a  [5];
  logic [127:0] out_data_a [5];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd [256];
  logic [7:0] inv [256];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .in_data  (in_data_a[g]),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .out_data (out_data_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] model(logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = fwd[d[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Full block through instance j with out_ready low until out_valid is seen.
  task automatic send(input int j, input logic [127:0] d, output logic [127:0] res);
    int w = 0;
    int lat = 0;
    @(negedge clk);
    out_ready_v[j] = 1'b0;
    while (!in_ready_v[j] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready before accept", 128'(in_ready_v[j]), 128'(1));
    in_valid_v[j] = 1'b1;
    in_data_a[j]  = d;
    @(posedge clk);
    #1;
    in_valid_v[j] = 1'b0;
    in_data_a[j]  = ~d;
    chk("in_ready after accept", 128'(in_ready_v[j]), 128'(0));
    while (!out_valid_v[j] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency bpc=%0d", 1 << j), 128'(lat), 128'(16 >> j));
    res = out_data_a[j];
    @(negedge clk);
    out_ready_v[j] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[j] = 1'b0;
    chk("in_ready after out accept", 128'(in_ready_v[j]), 128'(1));
    chk("out_valid after out accept", 128'(out_valid_v[j]), 128'(0));
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  initial begin
    vec_t         vecs [5];
    logic [127:0] res, d, exp;
    logic [7:0]   b, ib;
    bit           ok;

    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0eff, 128'h637c777bf26b6fc53001672bfed7ab16};
    vecs[2] = '{128'h53535353535353535353535353535353, 128'hedededededededededededededededed};
    vecs[3] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    vecs[4] = '{128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616};

    for (int x = 0; x < 256; x++) begin
      ib = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) ib = 8'(y);
      fwd[x] = ib ^ rotl8(ib, 1) ^ rotl8(ib, 2) ^ rotl8(ib, 3) ^ rotl8(ib, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv[fwd[x]] = 8'(x);

    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '0;
    for (int j = 0; j < 5; j++) in_data_a[j] = '0;
    #12;
    for (int j = 0; j < 5; j++) begin
      chk("reset in_ready", 128'(in_ready_v[j]), 128'(1));
      chk("reset out_valid", 128'(out_valid_v[j]), 128'(0));
      chk("reset out_data", out_data_a[j], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Known vectors on the default configuration (BYTES_PER_CYCLE=4).
    for (int v = 0; v < 5; v++) begin
      send(2, vecs[v].din, res);
      chk($sformatf("vector %0d", v), res, vecs[v].dout);
    end

    // Random blocks on every configuration against the reference model.
    for (int j = 0; j < 5; j++) begin
      for (int r = 0; r < 3; r++) begin
        d = rnd128();
        send(j, d, res);
        chk($sformatf("random bpc=%0d", 1 << j), res, model(d));
      end
    end

    // Round trip of all 256 byte values on every configuration.
    for (int j = 0; j < 5; j++) begin
      for (int blk = 0; blk < 16; blk++) begin
        for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = 8'(blk*16 + i);
        send(j, d, res);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          b = res[127 - 8*i -: 8];
          if (inv[b] != d[127 - 8*i -: 8]) ok = 1'b0;
        end
        chk($sformatf("round trip bpc=%0d blk=%0d", 1 << j, blk), 128'(ok), 128'(1));
      end
    end

    // Reset in the middle of BUSY: outputs return without a clock edge.
    @(negedge clk);
    d = 128'h0123456789abcdef0123456789abcdef;
    in_valid_v[2] = 1'b1;
    in_data_a[2]  = d;
    @(posedge clk);
    #1;
    in_valid_v[2] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-busy buffer nonzero", 128'(out_data_a[2] != '0), 128'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 128'(out_valid_v[2]), 128'(0));
    chk("async reset in_ready", 128'(in_ready_v[2]), 128'(1));
    chk("async reset out_data", out_data_a[2], '0);
    @(negedge clk);
    rst = 1'b0;
    d = rnd128();
    send(2, d, res);
    chk("block after reset", res, model(d));

    // Reset while DONE drops out_valid immediately.
    @(negedge clk);
    in_valid_v[2] = 1'b1;
    in_data_a[2]  = rnd128();
    @(posedge clk);
    #1;
    in_valid_v[2] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("done before reset", 128'(out_valid_v[2]), 128'(1));
    rst = 1'b1;
    #1;
    chk("reset in DONE out_valid", 128'(out_valid_v[2]), 128'(0));
    chk("reset in DONE out_data", out_data_a[2], '0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure with in_valid pulses during BUSY and DONE.
    d   = rnd128();
    exp = model(d);
    @(negedge clk);
    in_valid_v[2] = 1'b1;
    in_data_a[2]  = d;
    @(posedge clk);
    #1;
    in_data_a[2] = ~d;
    @(posedge clk);
    #1;
    in_valid_v[2] = 1'b0;
    begin
      int w = 0;
      while (!out_valid_v[2] && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
    end
    chk("backpressure first result", out_data_a[2], exp);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid_v[2] = k[0];
      in_data_a[2]  = rnd128();
      chk("backpressure out_valid held", 128'(out_valid_v[2]), 128'(1));
      chk("backpressure in_ready low", 128'(in_ready_v[2]), 128'(0));
      chk("backpressure data frozen", out_data_a[2], exp);
    end
    @(negedge clk);
    in_valid_v[2]  = 1'b0;
    out_ready_v[2] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[2] = 1'b0;
    chk("release in_ready", 128'(in_ready_v[2]), 128'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("pulsed data not captured", 128'({out_valid_v[2], in_ready_v[2]}), 128'(2'b01));

    // Back-to-back with in_valid and out_ready held high.
    for (int j = 0; j < 5; j++) begin
      logic [127:0] q [$];
      int cyc  = 0;
      int nacc = 0;
      int nout = 0;
      int last = -1;
      @(negedge clk);
      out_ready_v[j] = 1'b1;
      while (nout < 4 && cyc < 300) begin
        if (out_valid_v[j]) begin
          if (q.size() == 0) chk("b2b spurious output", 128'(1), 128'(0));
          else chk($sformatf("b2b data bpc=%0d", 1 << j), out_data_a[j], q.pop_front());
          nout++;
        end
        if (nacc < 4) begin
          d = rnd128();
          in_valid_v[j] = 1'b1;
          in_data_a[j]  = d;
          if (in_ready_v[j]) begin
            q.push_back(model(d));
            if (last >= 0) chk($sformatf("b2b gap bpc=%0d", 1 << j), 128'(cyc - last), 128'((16 >> j) + 2));
            last = cyc;
            nacc++;
          end
        end else begin
          in_valid_v[j] = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      in_valid_v[j]  = 1'b0;
      out_ready_v[j] = 1'b0;
      chk($sformatf("b2b output count bpc=%0d", 1 << j), 128'(nout), 128'(4));
      chk($sformatf("b2b nothing pending bpc=%0d", 1 << j), 128'(q.size()), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Sequential AES-128 forward SubBytes unit: it applies the FIPS-197 forward S-box to a 128-bit state. It processes BYTES_PER_CYCLE bytes per clock, with valid/ready handshakes on both input and output. It is the encrypt-direction counterpart of the inverse S-box used in the decrypt datapath, and sits between AddRoundKey and ShiftRows in the encryption round loop. The S-box is the exact inverse of the existing inverse S-box: InvSbox(S(x)) = x for all x.

## Interface
- BYTES_PER_CYCLE, default 4: bytes substituted per busy cycle.
  - Legal values: 1, 2, 4, 8, 16.
  - NCHUNK = 16/BYTES_PER_CYCLE.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state (high only in IDLE).
- in_data  input  128  state to substitute.
  - Byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  substituted state, same byte order.

## Operation
- Internal state:
  - 128-bit working register `buf`.
  - Chunk counter `cnt`, width clog2(NCHUNK), minimum 1 bit.
  - FSM with states IDLE, BUSY, DONE.
- Reset (async, rst=1): FSM=IDLE, cnt=0, buf=0. Outputs: in_ready=1, out_valid=0, out_data=0.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: buf<=in_data, cnt<=0, go BUSY.
  - in_valid=0: remain IDLE.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge: bytes cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 of buf are replaced by S(byte), in place. Chunk 0 is the MSB end.
  - If cnt==NCHUNK-1: go DONE, cnt<=0. Otherwise cnt<=cnt+1.
- DONE:
  - out_valid=1, out_data=buf. Both are held stable until accepted, independent of in_valid.
  - On edge with out_ready=1: go IDLE.
  - No same-edge acceptance of a new input from DONE.
- out_data is driven directly from buf in all states.
  - It is defined/meaningful only while out_valid=1.
  - It must be 0 after reset.
- S-box: BYTES_PER_CYCLE instances of a combinational forward S-box (full 256-entry FIPS-197 table). Each byte is substituted exactly once per block.
- Any byte value, including 00 and ff, is legal. No arithmetic other than the counter, which wraps to 0 only through the explicit BUSY→DONE transition.

## Timing
- Accept edge E (IDLE, in_valid=1):
  - BUSY occupies edges E+1 .. E+NCHUNK.
  - out_valid is high from just after edge E+NCHUNK.
  - Latency is NCHUNK cycles (default 4; 1 for BYTES_PER_CYCLE=16).
- in_ready falls just after E and returns high just after the out-accept edge.
- Minimum block period: NCHUNK+2 cycles (accept, NCHUNK busy edges, output handshake edge, then the next accept).
- out_ready held low indefinitely: remain in DONE with outputs frozen (backpressure).
- out_ready high before DONE: no effect.
- rst asserted mid-BUSY or in DONE: immediate return to the reset values. The partial result is discarded; out_valid drops without waiting for a clock.
- Deassertion of rst is synchronous to clk by the integration layer; the first accept is possible on the first edge after deassertion.

## Test plan
- Reset check:
  - Stimulus: assert rst mid-BUSY.
  - Required: out_valid=0, in_ready=1, out_data=0 immediately, without a clock edge.
  - After release, a new block completes correctly.
- FIPS-197 vector:
  - Stimulus: in_data=193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: out_data=d42711aee0bf98f1b8b45de51e415230, out_valid rising exactly 4 cycles after the accept edge (default parameter).
- Corner bytes:
  - Stimulus: in_data=000102030405060708090a0b0c0d0eff.
  - Required: out_data=637c777bf26b6fc53001672bfed7ab16.
  - S(53)=ed is checked in a separate block 5353…53 → eded…ed.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, and pulse in_valid with different data during BUSY and DONE.
  - Required: out_data and out_valid stay frozen and the pulsed data is never captured. Release out_ready → in_ready=1 on the next cycle.
- Round trip:
  - Stimulus: feed all 256 byte values (16 blocks) and pass each output byte through the inverse S-box.
  - Required: the original value is returned for every byte.
  - Repeat for BYTES_PER_CYCLE=1, 2, 4, 8, 16, checking latency = NCHUNK each time.
- Back-to-back: with in_valid and out_ready held high, consecutive accepts are exactly NCHUNK+2 cycles apart, and no block is lost or duplicated.
